// File: rtl/return_address_stack.sv
// Speculative return address stack for the branch predictor: pushes on predicted calls,
// predicts return targets, and repairs ptr/count from a checkpoint on a redirect.

`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif
`ifndef ABSOLUTE
`define ABSOLUTE 2'b00
`endif
`ifndef PC_RELATIVE
`define PC_RELATIVE 2'b01
`endif
`ifndef CALL
`define CALL 2'b10
`endif
`ifndef RETURN
`define RETURN 2'b11
`endif

module return_address_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
    parameter int unsigned VALEN = `PROC_VALEN
) (
    input  logic                   clk,
    input  logic                   a_rst_i,
    input  logic                   spec_valid_i,
    input  logic [1:0]             spec_br_type_i,
    input  logic [VALEN-1:0]       spec_pc_i,
    output logic [VALEN-1:0]       pred_target_o,
    output logic                   pred_valid_o,
    output logic [CNT_W+PTR_W-1:0] ckpt_o,
    input  logic                   redirect_i,
    input  logic [CNT_W+PTR_W-1:0] redirect_ckpt_i,
    input  logic [1:0]             redirect_br_type_i,
    input  logic [VALEN-1:0]       redirect_pc_i
);

    logic [VALEN-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_apply;
    logic [1:0]       w_type;
    logic [VALEN-1:0] w_pc;
    logic [PTR_W-1:0] w_base_ptr;
    logic [CNT_W-1:0] w_base_cnt;
    logic [PTR_W-1:0] w_nxt_ptr;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_push;
    logic [PTR_W-1:0] w_push_ptr;
    logic [VALEN-1:0] w_ret_addr;

    // Redirect wins over the fetch-side update and rebuilds from the carried checkpoint.
    always_comb begin
        if (redirect_i) begin
            w_apply    = 1'b1;
            w_type     = redirect_br_type_i;
            w_pc       = redirect_pc_i;
            w_base_ptr = redirect_ckpt_i[PTR_W-1:0];
            w_base_cnt = redirect_ckpt_i[CNT_W+PTR_W-1:PTR_W];
        end else begin
            w_apply    = spec_valid_i;
            w_type     = spec_br_type_i;
            w_pc       = spec_pc_i;
            w_base_ptr = r_ptr;
            w_base_cnt = r_count;
        end
    end

    always_comb begin
        w_nxt_ptr  = w_base_ptr;
        w_nxt_cnt  = w_base_cnt;
        w_push     = 1'b0;
        w_push_ptr = w_base_ptr + PTR_W'(1);
        w_ret_addr = w_pc + VALEN'(4);
        if (w_apply) begin
            case (w_type)
                `CALL: begin
                    w_push    = 1'b1;
                    w_nxt_ptr = w_push_ptr;
                    w_nxt_cnt = (w_base_cnt >= CNT_W'(DEPTH)) ? CNT_W'(DEPTH)
                                                              : w_base_cnt + CNT_W'(1);
                end
                `RETURN: begin
                    if (w_base_cnt != '0) begin
                        w_nxt_ptr = w_base_ptr - PTR_W'(1);
                        w_nxt_cnt = w_base_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_ptr   <= w_nxt_ptr;
            r_count <= w_nxt_cnt;
            if (w_push) begin
                r_stack[w_push_ptr] <= w_ret_addr;
            end
        end
    end

    assign pred_target_o = r_stack[r_ptr];
    assign pred_valid_o  = (r_count != '0);
    assign ckpt_o        = {r_count, r_ptr};

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: scoreboard of expected outputs from a
// behavioural stack model, plus directed checks against hand-derived constants.

`ifndef ABSOLUTE
`define ABSOLUTE 2'b00
`endif
`ifndef PC_RELATIVE
`define PC_RELATIVE 2'b01
`endif
`ifndef CALL
`define CALL 2'b10
`endif
`ifndef RETURN
`define RETURN 2'b11
`endif

module tb_return_address_stack;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int CNT_W = 5;
    localparam int VALEN = 32;
    localparam int CKW   = CNT_W + PTR_W;

    logic             clk = 1'b0;
    logic             a_rst_i = 1'b1;
    logic             spec_valid_i = 1'b0;
    logic [1:0]       spec_br_type_i = `ABSOLUTE;
    logic [VALEN-1:0] spec_pc_i = '0;
    logic [VALEN-1:0] pred_target_o;
    logic             pred_valid_o;
    logic [CKW-1:0]   ckpt_o;
    logic             redirect_i = 1'b0;
    logic [CKW-1:0]   redirect_ckpt_i = '0;
    logic [1:0]       redirect_br_type_i = `ABSOLUTE;
    logic [VALEN-1:0] redirect_pc_i = '0;

    return_address_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W), .VALEN(VALEN)) dut (
        .clk                (clk),
        .a_rst_i            (a_rst_i),
        .spec_valid_i       (spec_valid_i),
        .spec_br_type_i     (spec_br_type_i),
        .spec_pc_i          (spec_pc_i),
        .pred_target_o      (pred_target_o),
        .pred_valid_o       (pred_valid_o),
        .ckpt_o             (ckpt_o),
        .redirect_i         (redirect_i),
        .redirect_ckpt_i    (redirect_ckpt_i),
        .redirect_br_type_i (redirect_br_type_i),
        .redirect_pc_i      (redirect_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VALEN-1:0] tgt;
        logic             vld;
        logic [CKW-1:0]   ckpt;
    } exp_t;

    exp_t             exp_q[$];
    logic [CKW-1:0]   hist_q[$];
    int               n_checks = 0;
    int               n_fail = 0;

    logic [VALEN-1:0] m_stack [DEPTH];
    int               m_ptr;
    int               m_cnt;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_apply(input int p, input int c, input logic [1:0] t,
                                        input logic [VALEN-1:0] pc);
        m_ptr = p;
        m_cnt = c;
        if (t == `CALL) begin
            m_ptr = (p + 1) % DEPTH;
            m_stack[m_ptr] = pc + 32'd4;
            m_cnt = (c + 1 > DEPTH) ? DEPTH : c + 1;
        end else if (t == `RETURN && c != 0) begin
            m_ptr = (p + DEPTH - 1) % DEPTH;
            m_cnt = c - 1;
        end
    endfunction

    function automatic logic [CKW-1:0] model_ckpt();
        return {CNT_W'(m_cnt), PTR_W'(m_ptr)};
    endfunction

    task automatic step(input logic sv, input logic [1:0] st, input logic [VALEN-1:0] spc,
                        input logic rd, input logic [CKW-1:0] rck, input logic [1:0] rt,
                        input logic [VALEN-1:0] rpc);
        exp_t e;
        spec_valid_i       = sv;
        spec_br_type_i     = st;
        spec_pc_i          = spc;
        redirect_i         = rd;
        redirect_ckpt_i    = rck;
        redirect_br_type_i = rt;
        redirect_pc_i      = rpc;
        if (rd) model_apply(int'(rck[PTR_W-1:0]), int'(rck[CKW-1:PTR_W]), rt, rpc);
        else if (sv) model_apply(m_ptr, m_cnt, st, spc);
        exp_q.push_back('{tgt: m_stack[m_ptr], vld: (m_cnt != 0), ckpt: model_ckpt()});
        @(posedge clk);
        #1;
        spec_valid_i = 1'b0;
        redirect_i   = 1'b0;
        e = exp_q.pop_front();
        check("sb_target", 64'(pred_target_o), 64'(e.tgt));
        check("sb_valid", 64'(pred_valid_o), 64'(e.vld));
        check("sb_ckpt", 64'(ckpt_o), 64'(e.ckpt));
    endtask

    task automatic spec(input logic [1:0] t, input logic [VALEN-1:0] pc);
        step(1'b1, t, pc, 1'b0, '0, `ABSOLUTE, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_rst_i = 1'b1;
        model_reset();
        @(negedge clk);
        a_rst_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [CKW-1:0] saved_ckpt;

    initial begin
        model_reset();
        #12;
        check("rst_target", 64'(pred_target_o), 64'h0);
        check("rst_valid", 64'(pred_valid_o), 64'h0);
        check("rst_ckpt", 64'(ckpt_o), 64'h0);
        do_reset();

        // single call
        spec(`CALL, 32'h1C00_0100);
        check("t1_target", 64'(pred_target_o), 64'h1C00_0104);
        check("t1_valid", 64'(pred_valid_o), 64'h1);
        check("t1_ckpt", 64'(ckpt_o), 64'h11);

        // push three, pop four
        do_reset();
        spec(`CALL, 32'h100);
        spec(`CALL, 32'h200);
        spec(`CALL, 32'h300);
        check("t2_pop0", 64'(pred_target_o), 64'h304);
        spec(`RETURN, 32'h0);
        check("t2_pop1", 64'(pred_target_o), 64'h204);
        spec(`RETURN, 32'h0);
        check("t2_pop2", 64'(pred_target_o), 64'h104);
        spec(`RETURN, 32'h0);
        check("t2_empty", 64'(pred_valid_o), 64'h0);
        spec(`RETURN, 32'h0);
        check("t2_underflow", 64'(ckpt_o), 64'h0);

        // overflow wrap
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) spec(`CALL, 32'h1000 + 32'h10 * i);
        check("t3_sat", 64'(ckpt_o[CKW-1:PTR_W]), 64'(DEPTH));
        for (int i = DEPTH + 1; i >= 2; i--) begin
            check("t3_pop", 64'(pred_target_o), 64'(32'h1004 + 32'h10 * i));
            spec(`RETURN, 32'h0);
        end
        check("t3_empty", 64'(pred_valid_o), 64'h0);

        // checkpoint repair
        do_reset();
        spec(`CALL, 32'h50);
        saved_ckpt = ckpt_o;
        check("t4_ckpt", 64'(saved_ckpt), 64'(model_ckpt()));
        spec(`CALL, 32'h400);
        spec(`CALL, 32'h500);
        spec(`CALL, 32'h600);
        step(1'b0, `ABSOLUTE, '0, 1'b1, saved_ckpt, `CALL, 32'h400);
        check("t4_count", 64'(ckpt_o[CKW-1:PTR_W]), 64'(saved_ckpt[CKW-1:PTR_W] + 5'd1));
        check("t4_target", 64'(pred_target_o), 64'h404);

        // redirect beats simultaneous spec call
        step(1'b1, `CALL, 32'h900, 1'b1, ckpt_o, `ABSOLUTE, 32'h0);
        check("t5_target", 64'(pred_target_o), 64'h404);
        step(1'b0, `ABSOLUTE, '0, 1'b0, '0, `ABSOLUTE, '0);
        check("t5_no904", 64'(pred_target_o == 32'h904), 64'h0);

        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) spec(`CALL, 32'h2000 + 32'h100 * i);
        #2;
        a_rst_i = 1'b1;
        model_reset();
        #1;
        check("t6_target", 64'(pred_target_o), 64'h0);
        check("t6_valid", 64'(pred_valid_o), 64'h0);
        check("t6_ckpt", 64'(ckpt_o), 64'h0);
        #2;
        a_rst_i = 1'b0;
        @(posedge clk);
        #1;

        // random mix with redirects to recent checkpoints
        for (int n = 0; n < 400; n++) begin
            logic [1:0] t;
            logic [1:0] rt;
            int         r;
            t  = 2'($urandom_range(0, 3));
            rt = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            hist_q.push_back(model_ckpt());
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            if (r < 2) begin
                step(1'($urandom_range(0, 1)), t, $urandom, 1'b1,
                     hist_q[$urandom_range(0, hist_q.size() - 1)], rt, $urandom);
            end else begin
                step(1'(r < 8), t, $urandom, 1'b0, '0, `ABSOLUTE, '0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
